mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 2:1 select datapath.
- Grants the output to one valid/ready source per burst and drives the registered select line.
- Steers the granted source's data and last-beat flag to a single valid/ready sink.
- Sits between two producers and one downstream consumer. The mux is internal; sel is exported so external 2:1 select instances can be slaved to it.

Parameters:
- DATA_W, 8, payload width per requester.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in0_valid  input  1  requester 0 beat valid.
- in0_data  input  DATA_W  requester 0 payload.
- in0_last  input  1  requester 0 final beat of burst.
- in0_ready  output  1  requester 0 beat accepted when high with in0_valid.
- in1_valid / in1_data / in1_last / in1_ready: same as above, for requester 1.
- out_valid  output  1  granted beat valid to sink.
- out_data  output  DATA_W  granted payload.
- out_last  output  1  burst-terminating beat; high on in*_last or the MAX_BURST-th beat.
- out_ready  input  1  sink accepts beat.
- sel  output  1  registered grant; 0 = requester 0, 1 = requester 1.
- busy  output  1  high in GRANT0/GRANT1.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, sel = 0, beat count = 0.
  - Priority pointer favours requester 0 first.
  - out_valid = 0, in0_ready = in1_ready = 0, busy = 0.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Both valid: grant the requester not served last (pointer).
  - One valid: grant that requester.
  - None valid: stay in IDLE.
  - Grant is registered, so the first beat passes one cycle after the request is seen (1-cycle arbitration latency).
  - sel holds its last value in IDLE.
- GRANTx:
  - out_valid = inx_valid; out_data = inx_data.
  - inx_ready = out_ready; the other ready = 0.
  - Combinational valid/data/ready path, zero-latency pass-through.
- Beat accept: a beat is accepted when out_valid & out_ready. Each accepted beat increments the beat counter, width $clog2(MAX_BURST+1).
- Burst end: an accepted beat with inx_last = 1, or the accepted beat that makes count == MAX_BURST. out_last is asserted on that beat.
- At burst end:
  - Count clears.
  - Pointer flips to favour the other requester.
  - Re-arbitrate in the same edge with no bubble: other valid → GRANT(other); else this one valid → GRANTx again; else IDLE.
- Inside a burst, valid may drop. The grant is held, out_valid follows the source, and no timeout applies.
- The non-granted requester is never accepted mid-burst. Its ready stays 0.
- MAX_BURST = 1: every beat is a burst end, so requesters alternate beat-by-beat when both are valid.
- Async reset mid-burst drops the grant immediately and clears the count. The partial burst is not resumed.

Optional Feature:
- Macro MUX_ARBITER_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - Each counts burst grants to its requester: +1 on each entry to GRANTx, including back-to-back re-grants.
  - Counters saturate at 16'hFFFF and clear on reset.
  - Adds input stats_clr, a synchronous clear; clear wins over a same-cycle increment.
- When undefined: these ports and counters do not exist, and core behaviour is identical.

Decomposition:
- Package mux_arb_pkg holds:
  - arb_state_e enum {IDLE, GRANT0, GRANT1}.
  - Constants SEL_IN0 = 1'b0, SEL_IN1 = 1'b1.
  - STAT_W = 16.
- One sub-module, mux_arb_beat_cnt: the parameterised beat counter with clear/increment, providing a burst-limit flag.
- The FSM, pointer and steering stay in mux_arbiter.

Test Plan:
- Reset then idle: rst_n low mid-stream → all outputs 0, sel = 0. After release with no valids → state remains IDLE, busy = 0.
- Single requester: in1 sends 3 beats 0x11, 0x22, 0x33 with last on the third, out_ready = 1 → grant 1 cycle after valid. out_data 0x11, 0x22, 0x33 on consecutive cycles, out_last on 0x33, sel = 1.
- Contention fairness: both continuously valid with 2-beat bursts → grants alternate 0, 1, 0, 1 with no idle cycle between bursts. grant_cnt0 == grant_cnt1 after 8 bursts (stats build).
- Burst limit: MAX_BURST = 4, in0 sends 6 beats without last while in1 is valid → out_last forced on beat 4, then in1 is granted. in0's remaining beats are served after in1's burst.
- Backpressure and valid gaps: out_ready toggles 1010 and in0_valid drops for 2 cycles mid-burst → no beat lost or duplicated, in1_ready stays 0, count advances only on accepted beats.
- Reset mid-burst: assert rst_n after beat 2 of 4 → immediate IDLE, count = 0. After release with both valid → requester 0 is granted first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// Contents:
//   arb_state_e   - arbiter FSM states (IDLE, GRANT0, GRANT1)
//   SEL_IN0/1     - encodings of the exported select line
//   STAT_W        - width of the optional grant statistics counters
//   sat_inc()     - saturating increment used by the statistics counters
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_e;

   localparam logic SEL_IN0 = 1'b0;
   localparam logic SEL_IN1 = 1'b1;

   localparam int STAT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      logic [STAT_W-1:0] r;
      if (v == {STAT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + STAT_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_arb_beat_cnt.sv
// Beat counter for one arbitration burst.
// Counts accepted beats of the current burst and flags when the next accepted
// beat will be the MAX_BURST-th one, so the arbiter can force the burst end
// on that same beat.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear (burst end); has priority over inc
//   inc        - one accepted beat that does not end the burst
//   at_limit   - current count is MAX_BURST-1
module mux_arb_beat_cnt #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_BURST - 1);

   logic [CNT_W-1:0] count_r;

   // Burst beat counter: clear at burst end, otherwise count accepted beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (inc) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign at_limit = (count_r == LIMIT_M1);

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter and 2:1 steering for a valid/ready sink.
// One requester owns the output for a whole burst; the burst ends on an
// accepted beat carrying in*_last or on the MAX_BURST-th accepted beat, and the
// next owner is chosen on that same edge (no bubble). Data/valid/ready pass
// through combinationally while a grant is held; sel is the registered grant.
// Optional build macro: MUX_ARBITER_STATS_EN adds stats_clr, grant_cnt0/1.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   in0_valid/data/last, in0_ready  - requester 0 handshake
//   in1_valid/data/last, in1_ready  - requester 1 handshake
//   out_valid/data/last, out_ready  - sink handshake
//   sel                             - registered grant (0 = in0, 1 = in1)
//   busy                            - a grant is held
//   stats_clr, grant_cnt0/1         - (stats build) grant counters and clear
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_valid,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_last,
   output logic              in0_ready,
   input  logic              in1_valid,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_last,
   output logic              in1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy
`ifdef MUX_ARBITER_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [STAT_W-1:0] grant_cnt0,
   output logic [STAT_W-1:0] grant_cnt1
`endif
);

   arb_state_e state_r;
   arb_state_e state_nxt_s;
   logic       sel_r;
   logic       ptr_r;        // requester favoured when both request from IDLE
   logic       busy_r;
   logic       accept_s;
   logic       burst_end_s;
   logic       at_limit_s;

   mux_arb_beat_cnt #(
      .MAX_BURST (MAX_BURST)
   ) u_beat_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (burst_end_s),
      .inc      (accept_s),
      .at_limit (at_limit_s)
   );

   // Next-state selection and combinational steering of the granted source.
   always_comb begin
      state_nxt_s = state_r;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      in0_ready   = 1'b0;
      in1_ready   = 1'b0;
      accept_s    = 1'b0;
      burst_end_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (in0_valid && in1_valid) begin
               state_nxt_s = (ptr_r == SEL_IN1) ? GRANT1 : GRANT0;
            end else if (in0_valid) begin
               state_nxt_s = GRANT0;
            end else if (in1_valid) begin
               state_nxt_s = GRANT1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT0: begin
            out_valid   = in0_valid;
            out_data    = in0_data;
            out_last    = in0_valid & (in0_last | at_limit_s);
            in0_ready   = out_ready;
            accept_s    = in0_valid & out_ready;
            burst_end_s = accept_s & (in0_last | at_limit_s);
            // The other requester gets the next burst whenever it is waiting.
            if (burst_end_s) begin
               if (in1_valid) begin
                  state_nxt_s = GRANT1;
               end else if (in0_valid) begin
                  state_nxt_s = GRANT0;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = GRANT0;
            end
         end
         GRANT1: begin
            out_valid   = in1_valid;
            out_data    = in1_data;
            out_last    = in1_valid & (in1_last | at_limit_s);
            in1_ready   = out_ready;
            accept_s    = in1_valid & out_ready;
            burst_end_s = accept_s & (in1_last | at_limit_s);
            if (burst_end_s) begin
               if (in0_valid) begin
                  state_nxt_s = GRANT0;
               end else if (in1_valid) begin
                  state_nxt_s = GRANT1;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = GRANT1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, select, pointer and busy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         sel_r   <= SEL_IN0;
         ptr_r   <= SEL_IN0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != IDLE);
         // sel tracks the granted requester and keeps its value through IDLE.
         case (state_nxt_s)
            GRANT0:  sel_r <= SEL_IN0;
            GRANT1:  sel_r <= SEL_IN1;
            default: sel_r <= sel_r;
         endcase
         // After a burst, favour the requester that was not just served.
         if (burst_end_s) begin
            ptr_r <= (state_r == GRANT0) ? SEL_IN1 : SEL_IN0;
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   assign sel  = sel_r;
   assign busy = busy_r;

`ifdef MUX_ARBITER_STATS_EN
   logic              grant_evt0_s;
   logic              grant_evt1_s;
   logic [STAT_W-1:0] grant_cnt0_r;
   logic [STAT_W-1:0] grant_cnt1_r;

   // A grant event is any entry into GRANTx, including a re-grant at burst end.
   always_comb begin
      grant_evt0_s = (state_nxt_s == GRANT0) && ((state_r != GRANT0) || burst_end_s);
      grant_evt1_s = (state_nxt_s == GRANT1) && ((state_r != GRANT1) || burst_end_s);
   end

   // Saturating grant counters; a synchronous clear beats a same-cycle grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_r <= '0;
         grant_cnt1_r <= '0;
      end else if (stats_clr) begin
         grant_cnt0_r <= '0;
         grant_cnt1_r <= '0;
      end else begin
         grant_cnt0_r <= grant_evt0_s ? sat_inc(grant_cnt0_r) : grant_cnt0_r;
         grant_cnt1_r <= grant_evt1_s ? sat_inc(grant_cnt1_r) : grant_cnt1_r;
      end
   end

   assign grant_cnt0 = grant_cnt0_r;
   assign grant_cnt1 = grant_cnt1_r;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (DATA_W = 8, MAX_BURST = 4).
module tb_mux_arbiter;

   localparam int DW   = 8;
   localparam int MAXB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in0_valid, in0_last, in0_ready;
   logic [DW-1:0] in0_data;
   logic          in1_valid, in1_last, in1_ready;
   logic [DW-1:0] in1_data;
   logic          out_valid, out_last, out_ready;
   logic [DW-1:0] out_data;
   logic          sel, busy;
`ifdef MUX_ARBITER_STATS_EN
   logic          stats_clr;
   logic [15:0]   grant_cnt0, grant_cnt1;
`endif

   always #5 clk = ~clk;

   mux_arbiter #(.DATA_W(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .sel(sel), .busy(busy)
`ifdef MUX_ARBITER_STATS_EN
      , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (who owns the output, beats taken) ----
   int m_owner;   // -1 = nobody, else requester index
   int m_beats;   // beats accepted in the current burst
   int m_fav;     // requester preferred on a tie from idle
   int m_sel;
   int m_gcnt [2];

   task automatic model_reset();
      m_owner = -1; m_beats = 0; m_fav = 0; m_sel = 0;
      m_gcnt[0] = 0; m_gcnt[1] = 0;
   endtask

   task automatic check_outputs(input string tag);
      logic v [2];
      logic l [2];
      logic [DW-1:0] d [2];
      v[0] = in0_valid; v[1] = in1_valid;
      l[0] = in0_last;  l[1] = in1_last;
      d[0] = in0_data;  d[1] = in1_data;
      chk({tag, "_busy"}, busy, (m_owner >= 0) ? 1 : 0);
      chk({tag, "_sel"}, sel, m_sel);
      if (m_owner < 0) begin
         chk({tag, "_ovalid"}, out_valid, 0);
         chk({tag, "_rdy0"}, in0_ready, 0);
         chk({tag, "_rdy1"}, in1_ready, 0);
      end else begin
         chk({tag, "_ovalid"}, out_valid, v[m_owner]);
         chk({tag, "_rdy0"}, in0_ready, (m_owner == 0) ? out_ready : 1'b0);
         chk({tag, "_rdy1"}, in1_ready, (m_owner == 1) ? out_ready : 1'b0);
         if (v[m_owner]) begin
            chk({tag, "_odata"}, out_data, d[m_owner]);
            chk({tag, "_olast"}, out_last, (l[m_owner] || (m_beats + 1 == MAXB)) ? 1 : 0);
         end
      end
`ifdef MUX_ARBITER_STATS_EN
      chk({tag, "_gcnt0"}, grant_cnt0, m_gcnt[0]);
      chk({tag, "_gcnt1"}, grant_cnt1, m_gcnt[1]);
`endif
   endtask

   task automatic model_edge();
      logic v [2];
      logic l [2];
      int entered;
      v[0] = in0_valid; v[1] = in1_valid;
      l[0] = in0_last;  l[1] = in1_last;
      entered = -1;
      if (m_owner < 0) begin
         if (v[0] && v[1]) entered = m_fav;
         else if (v[0])    entered = 0;
         else if (v[1])    entered = 1;
         if (entered >= 0) begin
            m_owner = entered; m_sel = entered;
         end
      end else if (v[m_owner] && out_ready) begin
         m_beats++;
         if (l[m_owner] || m_beats == MAXB) begin
            m_beats = 0;
            m_fav   = 1 - m_owner;
            if (v[1 - m_owner]) m_owner = 1 - m_owner;
            m_sel   = m_owner;
            entered = m_owner;
         end
      end
`ifdef MUX_ARBITER_STATS_EN
      if (stats_clr) begin
         m_gcnt[0] = 0; m_gcnt[1] = 0;
      end else if (entered >= 0 && m_gcnt[entered] < 65535) begin
         m_gcnt[entered]++;
      end
`endif
   endtask

   // ---------------- requester drivers and output log ---------------------
   logic [DW-1:0] q0_d[$], q1_d[$];
   logic          q0_l[$], q1_l[$];
   logic          hold0 = 1'b0, hold1 = 1'b0;
   logic [DW-1:0] log_d[$];
   logic          log_l[$], log_s[$];

   task automatic push0(input logic [DW-1:0] d, input logic l);
      q0_d.push_back(d); q0_l.push_back(l);
   endtask
   task automatic push1(input logic [DW-1:0] d, input logic l);
      q1_d.push_back(d); q1_l.push_back(l);
   endtask

   task automatic clear_all();
      q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
      log_d.delete(); log_l.delete(); log_s.delete();
      hold0 = 1'b0; hold1 = 1'b0;
   endtask

   // One clock of driver + model; inputs change #1 after the rising edge.
   task automatic cycle(input string tag, input logic ordy);
      logic a0, a1;
      out_ready = ordy;
      in0_valid = (q0_d.size() > 0) && !hold0;
      in0_data  = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
      in0_last  = (q0_d.size() > 0) ? q0_l[0] : 1'b0;
      in1_valid = (q1_d.size() > 0) && !hold1;
      in1_data  = (q1_d.size() > 0) ? q1_d[0] : 8'h00;
      in1_last  = (q1_d.size() > 0) ? q1_l[0] : 1'b0;
      @(negedge clk);
      check_outputs(tag);
      a0 = in0_valid & in0_ready;
      a1 = in1_valid & in1_ready;
      if (out_valid && out_ready) begin
         log_d.push_back(out_data); log_l.push_back(out_last); log_s.push_back(sel);
      end
      model_edge();
      @(posedge clk); #1;
      if (a0) begin void'(q0_d.pop_front()); void'(q0_l.pop_front()); end
      if (a1) begin void'(q1_d.pop_front()); void'(q1_l.pop_front()); end
   endtask

   task automatic chk_log(input string name, input int idx, input logic [DW-1:0] d,
                          input logic l, input logic s);
      if (idx >= log_d.size()) begin
         n_checks++; n_errors++;
         $display("FAIL %s: beat %0d missing, only %0d beats seen", name, idx, log_d.size());
      end else begin
         chk({name, "_data"}, log_d[idx], d);
         chk({name, "_last"}, log_l[idx], l);
         chk({name, "_sel"},  log_s[idx], s);
      end
   endtask

   // Asynchronous reset asserted between edges while inputs keep driving.
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_ovalid"}, out_valid, 0);
      chk({tag, "_odata"},  out_data, 0);
      chk({tag, "_olast"},  out_last, 0);
      chk({tag, "_rdy0"},   in0_ready, 0);
      chk({tag, "_rdy1"},   in1_ready, 0);
      chk({tag, "_sel"},    sel, 0);
      chk({tag, "_busy"},   busy, 0);
      model_reset();
      clear_all();
      in0_valid = 1'b0; in1_valid = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- directed table ---------------------------------------
   typedef struct {
      logic v0; logic [DW-1:0] d0; logic l0;
      logic v1; logic [DW-1:0] d1; logic l1;
      logic ordy;
      logic e_ov; logic [DW-1:0] e_od; logic e_ol;
      logic e_r0; logic e_r1; logic e_sel; logic e_busy;
   } vec_t;

   vec_t tbl [4];

   initial begin
      rst_n = 1'b0;
      in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
      in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
      out_ready = 1'b0;
`ifdef MUX_ARBITER_STATS_EN
      stats_clr = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Idle after reset with no requests.
      for (int i = 0; i < 3; i++) cycle("idle", 1'b1);

      // Single requester in1: grant one cycle after valid, three beats.
      //          v0 d0     l0    v1    d1     l1    rdy   ov    od     ol    r0    r1    sel   busy
      tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         in0_valid = tbl[i].v0; in0_data = tbl[i].d0; in0_last = tbl[i].l0;
         in1_valid = tbl[i].v1; in1_data = tbl[i].d1; in1_last = tbl[i].l1;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         chk("tbl_ovalid", out_valid, tbl[i].e_ov);
         if (tbl[i].e_ov) begin
            chk("tbl_odata", out_data, tbl[i].e_od);
            chk("tbl_olast", out_last, tbl[i].e_ol);
         end
         chk("tbl_rdy0", in0_ready, tbl[i].e_r0);
         chk("tbl_rdy1", in1_ready, tbl[i].e_r1);
         chk("tbl_sel",  sel,       tbl[i].e_sel);
         chk("tbl_busy", busy,      tbl[i].e_busy);
         model_edge();
         @(posedge clk); #1;
      end

      // Mid-stream asynchronous reset.
      in1_valid = 1'b1; in0_valid = 1'b1;
      async_reset("rst_mid");
      for (int i = 0; i < 2; i++) cycle("post_rst_idle", 1'b1);

      // Burst limit: in0 has 6 beats without last while in1 waits.
      for (int i = 0; i < 6; i++) push0(8'(i), 1'b0);
      push1(8'hA0, 1'b0); push1(8'hA1, 1'b1);
      for (int i = 0; i < 12; i++) cycle("blim", 1'b1);
      chk_log("blim0", 0, 8'h00, 1'b0, 1'b0);
      chk_log("blim2", 2, 8'h02, 1'b0, 1'b0);
      chk_log("blim3", 3, 8'h03, 1'b1, 1'b0);
      chk_log("blim4", 4, 8'hA0, 1'b0, 1'b1);
      chk_log("blim5", 5, 8'hA1, 1'b1, 1'b1);
      chk_log("blim6", 6, 8'h04, 1'b0, 1'b0);
      chk_log("blim7", 7, 8'h05, 1'b0, 1'b0);

      // Contention fairness: 8 two-beat bursts each, back to back.
      async_reset("rst_fair");
      for (int i = 0; i < 16; i++) begin
         push0(8'(i), 1'(i % 2));
         push1(8'(8'h80 + i), 1'(i % 2));
      end
      for (int i = 0; i < 33; i++) cycle("fair", 1'b1);
      chk("fair_beats", log_d.size(), 32);
      for (int k = 0; k < 32; k++) begin
         int b, idx;
         b = k / 2;
         idx = (b / 2) * 2 + (k % 2);
         chk_log("fair", k, (b % 2) ? 8'(8'h80 + idx) : 8'(idx), 1'(k % 2), 1'(b % 2));
      end

      // Backpressure 1010 with a two-cycle valid gap on in0.
      async_reset("rst_bp");
      push0(8'h40, 1'b0); push0(8'h41, 1'b0); push0(8'h42, 1'b0); push0(8'h43, 1'b1);
      push1(8'h50, 1'b0); push1(8'h51, 1'b1);
      for (int i = 0; i < 24; i++) begin
         hold0 = (i == 3 || i == 4);
         cycle("bp", 1'(i % 2 == 0));
      end
      hold0 = 1'b0;
      chk("bp_beats", log_d.size(), 6);
      chk_log("bp0", 0, 8'h40, 1'b0, 1'b0);
      chk_log("bp1", 1, 8'h41, 1'b0, 1'b0);
      chk_log("bp2", 2, 8'h42, 1'b0, 1'b0);
      chk_log("bp3", 3, 8'h43, 1'b1, 1'b0);
      chk_log("bp4", 4, 8'h50, 1'b0, 1'b1);
      chk_log("bp5", 5, 8'h51, 1'b1, 1'b1);

      // Reset after beat 2 of 4; count must restart, in0 first again.
      async_reset("rst_pre");
      push0(8'h60, 1'b0); push0(8'h61, 1'b0); push0(8'h62, 1'b0); push0(8'h63, 1'b1);
      push1(8'h70, 1'b0); push1(8'h71, 1'b1);
      for (int i = 0; i < 3; i++) cycle("mid", 1'b1);
      in0_valid = 1'b1; in1_valid = 1'b1;
      async_reset("rst_burst");
      push0(8'h64, 1'b0); push0(8'h65, 1'b0); push0(8'h66, 1'b0); push0(8'h67, 1'b0);
      push1(8'h70, 1'b0); push1(8'h71, 1'b1);
      for (int i = 0; i < 8; i++) cycle("after_rst", 1'b1);
      chk_log("arst0", 0, 8'h64, 1'b0, 1'b0);
      chk_log("arst2", 2, 8'h66, 1'b0, 1'b0);
      chk_log("arst3", 3, 8'h67, 1'b1, 1'b0);
      chk_log("arst4", 4, 8'h70, 1'b0, 1'b1);

      // Randomised traffic against the model, with one reset in the middle.
      async_reset("rst_rand");
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            in0_valid = 1'b1;
            async_reset("rst_rand_mid");
         end
         if (q0_d.size() < 3 && $urandom_range(3) == 0)
            push0(8'($urandom), 1'($urandom_range(2) == 0));
         if (q1_d.size() < 3 && $urandom_range(3) == 0)
            push1(8'($urandom), 1'($urandom_range(2) == 0));
         hold0 = ($urandom_range(4) == 0);
         hold1 = ($urandom_range(4) == 0);
`ifdef MUX_ARBITER_STATS_EN
         stats_clr = ($urandom_range(63) == 0);
`endif
         cycle("rand", 1'($urandom_range(3) != 0));
         if (log_d.size() > 64) begin
            log_d.delete(); log_l.delete(); log_s.delete();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
